// File: rtl/volts_scale_ctrl.sv
// Purpose: selects a 1-of-3 voltage scale, from debounced-by-lockout buttons or by windowed peak auto-ranging.
// Latency: button rise -> new scale in 3 cycles; auto window end -> new scale 2 cycles after the last sample.
// Backpressure: none; samples are consumed whenever sample_valid is high in MEASURE, ignored otherwise.
module volts_scale_ctrl #(
  parameter int         WINDOW  = 256,
  parameter logic [7:0] HI_TH   = 8'd200,
  parameter logic [7:0] LO_TH   = 8'd64,
  parameter int         LOCKOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       auto_en,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic [2:0] volts_scale,
  output logic       scale_changed,
  output logic       range_busy
);

  localparam int             LW        = (LOCKOUT > 1) ? $clog2(LOCKOUT + 1) : 1;
  localparam logic [LW-1:0]  LOCK_LOAD = LW'(LOCKOUT);
  localparam logic [15:0]    WIN_LAST  = 16'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DECIDE,
    S_APPLY
  } state_t;

  // Button synchronizers plus one history flop for rising-edge detection.
  logic up_meta_q, up_sync_q, up_prev_q;
  logic dn_meta_q, dn_sync_q, dn_prev_q;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    dec_q, dec_d;
  logic [7:0]    peak_q, peak_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          changed_q;

  logic up_press, dn_press, lock_idle, man_accept;

  assign up_press   = up_sync_q & ~up_prev_q;
  assign dn_press   = dn_sync_q & ~dn_prev_q;
  assign lock_idle  = (lock_q == '0);
  // Simultaneous presses cancel each other and do not arm the lockout.
  assign man_accept = ~auto_en & lock_idle & (up_press ^ dn_press);

  // Two-flop synchronizers and edge-history flops for both buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      up_prev_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      up_meta_q <= btn_up;
      up_sync_q <= up_meta_q;
      up_prev_q <= up_sync_q;
      dn_meta_q <= btn_dn;
      dn_sync_q <= dn_meta_q;
      dn_prev_q <= dn_sync_q;
    end
  end

  // Lockout counter: reloaded by any accepted press, otherwise counts down to zero in every mode.
  always_comb begin
    lock_d = lock_q;
    if (man_accept) begin
      lock_d = LOCK_LOAD;
    end else if (!lock_idle) begin
      lock_d = lock_q - 1'b1;
    end
  end

  // Next-state logic: manual index stepping when auto is off, auto-range FSM otherwise.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    if (!auto_en) begin
      // Leaving auto mode drops any measurement or pending decision; the scale stays put.
      state_d = S_IDLE;
      peak_d  = 8'd0;
      cnt_d   = 16'd0;
      if (man_accept) begin
        if (up_press && idx_q != 2'd2) begin
          idx_d = idx_q + 2'd1;
        end else if (dn_press && idx_q != 2'd0) begin
          idx_d = idx_q - 2'd1;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_MEASURE;
          peak_d  = 8'd0;
          cnt_d   = 16'd0;
        end
        S_MEASURE: begin
          if (sample_valid) begin
            peak_d = (sample > peak_q) ? sample : peak_q;
            cnt_d  = cnt_q + 16'd1;
            if (cnt_q == WIN_LAST) begin
              state_d = S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          if (peak_q >= HI_TH && idx_q != 2'd0) begin
            dec_d = idx_q - 2'd1;
          end else if (peak_q < LO_TH && idx_q != 2'd2) begin
            dec_d = idx_q + 2'd1;
          end else begin
            dec_d = idx_q;
          end
          state_d = S_APPLY;
        end
        S_APPLY: begin
          idx_d   = dec_q;
          state_d = S_MEASURE;
          peak_d  = 8'd0;
          cnt_d   = 16'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, index, measurement and change-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      dec_q     <= 2'd0;
      peak_q    <= 8'd0;
      cnt_q     <= 16'd0;
      lock_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dec_q     <= dec_d;
      peak_q    <= peak_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      changed_q <= (idx_d != idx_q);
    end
  end

  // One-hot scale decode; the unused index code falls back to the lowest scale.
  always_comb begin
    volts_scale = 3'b001;
    case (idx_q)
      2'd1:    volts_scale = 3'b010;
      2'd2:    volts_scale = 3'b100;
      default: volts_scale = 3'b001;
    endcase
  end

  assign scale_changed = changed_q;
  assign range_busy    = (state_q == S_MEASURE) || (state_q == S_DECIDE);

endmodule

// File: tb/tb_volts_scale_ctrl.sv
module tb_volts_scale_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       auto_en = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'hFF;
  logic [2:0] volts_scale;
  logic       scale_changed;
  logic       range_busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] prev_vs = 3'b001;

  volts_scale_ctrl #(
    .WINDOW (4),
    .HI_TH  (8'd200),
    .LO_TH  (8'd64),
    .LOCKOUT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_dn       (btn_dn),
    .auto_en      (auto_en),
    .sample_valid (sample_valid),
    .sample       (sample),
    .volts_scale  (volts_scale),
    .scale_changed(scale_changed),
    .range_busy   (range_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up = up;
    btn_dn = dn;
    tick(1);
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    sample_valid = 1'b1;
    sample = s;
    tick(1);
    sample_valid = 1'b0;
    sample = 8'hFF;
  endtask

  // Four valid samples with idle (invalid, 255-valued) cycles mixed in.
  task automatic window4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a);
    tick(1);
    send(b);
    send(c);
    tick(1);
    send(d);
  endtask

  task automatic run_window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [2:0] old_vs, input logic [2:0] new_vs);
    if (new_vs != old_vs) exp_q.push_back(new_vs);
    window4(a, b, c, d);
    chk("busy_decide", range_busy, 1);
    tick(1);
    chk("busy_apply", range_busy, 0);
    chk("vs_apply", volts_scale, old_vs);
    tick(1);
    chk("vs_window", volts_scale, new_vs);
    chk("busy_measure", range_busy, 1);
    chk("pulse_window", scale_changed, (new_vs != old_vs));
  endtask

  // Output monitor: one-hot legality, pulse-on-change, and scoreboard pop on each pulse.
  always @(negedge clk) begin
    if (reset) begin
      prev_vs = 3'b001;
    end else begin
      chk("one_hot", $onehot(volts_scale), 1);
      chk("pulse_vs_change", scale_changed, (volts_scale !== prev_vs));
      if (scale_changed) begin
        chk("sb_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("sb_vs", volts_scale, exp_q.pop_front());
      end
      prev_vs = volts_scale;
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_vs", volts_scale, 3'b001);
    chk("rst_pulse", scale_changed, 0);
    chk("rst_busy", range_busy, 0);
    reset = 1'b0;
    tick(2);

    // Manual up presses 12 cycles apart; the third saturates
    exp_q.push_back(3'b010);
    press(1'b1, 1'b0);
    tick(1);
    chk("lat_before", volts_scale, 3'b001);
    tick(1);
    chk("lat_after", volts_scale, 3'b010);
    chk("lat_pulse", scale_changed, 1);
    tick(9);
    exp_q.push_back(3'b100);
    press(1'b1, 1'b0);
    tick(11);
    chk("up2_vs", volts_scale, 3'b100);
    press(1'b1, 1'b0);
    tick(3);
    // Saturated press must still arm the lockout, so this down press is dropped
    press(1'b0, 1'b1);
    tick(12);
    chk("sat_lockout_vs", volts_scale, 3'b100);

    // Second press 4 cycles after the first falls inside lockout
    exp_q.push_back(3'b010);
    press(1'b0, 1'b1);
    tick(3);
    press(1'b0, 1'b1);
    tick(12);
    chk("lockout_vs", volts_scale, 3'b010);

    // Simultaneous up+down ignored without lockout; next single press accepted
    press(1'b1, 1'b1);
    tick(1);
    exp_q.push_back(3'b100);
    press(1'b1, 1'b0);
    chk("simul_vs", volts_scale, 3'b010);
    tick(2);
    chk("after_simul_vs", volts_scale, 3'b100);
    tick(12);

    // Asynchronous reset while at the top scale, then auto mode from reset release
    reset = 1'b1;
    auto_en = 1'b1;
    #1;
    chk("arst_vs", volts_scale, 3'b001);
    chk("arst_pulse", scale_changed, 0);
    chk("arst_busy", range_busy, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("auto_enter_busy", range_busy, 1);

    // Auto-range windows
    run_window(8'd10, 8'd20, 8'd30, 8'd40, 3'b001, 3'b010);
    press(1'b1, 1'b0);
    tick(4);
    chk("auto_btn_ignored", volts_scale, 3'b010);
    run_window(8'd5, 8'd250, 8'd7, 8'd9, 3'b010, 3'b001);
    run_window(8'd10, 8'd10, 8'd10, 8'd10, 3'b001, 3'b010);
    run_window(8'd100, 8'd100, 8'd100, 8'd100, 3'b010, 3'b010);
    run_window(8'd1, 8'd2, 8'd3, 8'd4, 3'b010, 3'b100);
    run_window(8'd255, 8'd255, 8'd255, 8'd255, 3'b100, 3'b010);
    run_window(8'd0, 8'd0, 8'd0, 8'd0, 3'b010, 3'b100);

    // auto_en drops mid-window
    send(8'd255);
    send(8'd255);
    send(8'd255);
    auto_en = 1'b0;
    tick(1);
    chk("abort_busy", range_busy, 0);
    chk("abort_vs", volts_scale, 3'b100);
    tick(3);
    chk("abort_vs_hold", volts_scale, 3'b100);

    // auto_en drops while a decision is pending
    auto_en = 1'b1;
    tick(1);
    chk("reenter_busy", range_busy, 1);
    window4(8'd255, 8'd255, 8'd255, 8'd255);
    chk("pend_busy", range_busy, 1);
    auto_en = 1'b0;
    tick(1);
    chk("discard_busy", range_busy, 0);
    tick(3);
    chk("discard_vs", volts_scale, 3'b100);

    // Reset mid-window clears outputs without waiting for a clock
    auto_en = 1'b1;
    tick(1);
    send(8'd50);
    send(8'd60);
    reset = 1'b1;
    #1;
    chk("midwin_rst_vs", volts_scale, 3'b001);
    chk("midwin_rst_pulse", scale_changed, 0);
    chk("midwin_rst_busy", range_busy, 0);
    tick(2);
    auto_en = 1'b0;
    reset = 1'b0;
    tick(2);
    chk("post_rst_busy", range_busy, 0);

    // Manual control works again after reset
    exp_q.push_back(3'b010);
    press(1'b1, 1'b0);
    tick(2);
    chk("post_rst_up", volts_scale, 3'b010);
    tick(4);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/volts_scale_ctrl.md
VOLTS_SCALE_CTRL -- requirements
Module: volts_scale_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 256: number of accepted samples per auto-range measurement window (range 2..65535).
REQ-002 SHALL have parameter HI_TH, default 8'd200: peak at or above this value steps the scale down.
REQ-003 SHALL have parameter LO_TH, default 8'd64: peak below this value steps the scale up.
REQ-004 SHALL have parameter LOCKOUT, default 50000: cycles during which both buttons are ignored after an accepted press.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_up  input  1  raw button level, asynchronous to clk.
REQ-008 btn_dn  input  1  raw button level, asynchronous to clk.
REQ-009 auto_en  input  1  1 = auto-range mode, 0 = manual mode.
REQ-010 sample_valid  input  1  qualifies sample for one cycle.
REQ-011 sample  input  8  unsigned ADC sample.
REQ-012 volts_scale  output  3  one-hot scale select for the scaling datapath: 001, 010 or 100.
REQ-013 scale_changed  output  1  one-cycle pulse when volts_scale changes.
REQ-014 range_busy  output  1  high while auto mode is measuring or deciding.

Function
REQ-015 Scale index SHALL be 0/1/2 mapped to volts_scale 001/010/100; any other volts_scale value SHALL never be driven.
REQ-016 btn_up and btn_dn SHALL each pass through a 2-flop synchronizer; a press is the rising edge of the synchronized level.
REQ-017 Manual mode: accepted btn_up press SHALL increment index, saturating at 2; accepted btn_dn press SHALL decrement index, saturating at 0.
REQ-018 Update latency SHALL be 3 cycles from raw button rise to new volts_scale (2 sync + 1 edge/register).
REQ-019 Simultaneous up and down presses in the same cycle SHALL both be ignored and SHALL NOT start lockout.
REQ-020 Any accepted press SHALL load a lockout counter with LOCKOUT; while nonzero, all presses are ignored; a saturated press (no index change) still starts lockout.
REQ-021 Auto mode FSM states: IDLE, MEASURE, DECIDE, APPLY.
REQ-022 IDLE -> MEASURE when auto_en=1; peak register cleared to 0 and sample counter cleared on entry to MEASURE.
REQ-023 MEASURE: on each sample_valid, peak := max(peak, sample) and counter increments; after the WINDOW-th valid sample -> DECIDE.
REQ-024 DECIDE (1 cycle): peak >= HI_TH and index > 0 -> index-1; else peak < LO_TH and index < 2 -> index+1; otherwise hold.
REQ-025 APPLY (1 cycle): register new index; -> MEASURE (peak/counter cleared).
REQ-026 scale_changed SHALL pulse high for exactly one cycle, coincident with the first cycle volts_scale shows the new value, in both modes; never on saturation or hold.
REQ-027 range_busy SHALL be 1 in MEASURE and DECIDE, 0 in IDLE and APPLY.
REQ-028 Buttons SHALL be ignored while auto_en=1; lockout counter keeps counting down.
REQ-029 auto_en falling in any auto state SHALL return the FSM to IDLE next cycle, keeping the current volts_scale; a pending DECIDE result SHALL be discarded.
REQ-030 Samples with sample_valid=0 SHALL have no effect; sample 8'd255 SHALL be a valid peak (no overflow).

Reset
REQ-031 On reset assertion, immediately: volts_scale=3'b001, scale_changed=0, range_busy=0, FSM=IDLE, peak=0, sample counter=0, lockout=0, synchronizers=0.
REQ-032 Reset asserted mid-window SHALL abandon the measurement; after release with auto_en=1, FSM enters MEASURE on the first clock edge.

Verification (WINDOW=4, HI_TH=200, LO_TH=64, LOCKOUT=8)
REQ-033 Reset, manual, btn_up pulses 3x spaced 12 cycles -> volts_scale 010, 100, 100; scale_changed pulses twice; third press starts lockout but no pulse.
REQ-034 Manual, btn_up press then second btn_up press 4 cycles later -> only first accepted; volts_scale=010.
REQ-035 Manual, btn_up and btn_dn rise in same cycle at index 1 -> volts_scale stays 010, no pulse; next single press 1 cycle later accepted.
REQ-036 Auto, index 0, samples 10,20,30,40 -> DECIDE steps to 010, scale_changed 1 cycle; then samples 5,250,7,9 -> back to 001.
REQ-037 Auto, index 2, samples 255,255,255 then auto_en=0 before 4th -> FSM IDLE, volts_scale stays 100, no pulse, range_busy=0.
REQ-038 Auto, samples 100x4 at index 1 -> hold at 010, no pulse; reset mid-window -> all outputs at reset values asynchronously.
